// File: rtl/line_code_scanner_if.sv
// Load/commit handshake and scan outputs between a display-content source and the scanner.
// The source drives the master side; the scanner drives the slave side.
interface line_code_scanner_if #(
    parameter int NDIG = 4,
    parameter int IW   = $clog2(NDIG)
);
    logic            enable;
    logic            load_valid;
    logic            load_ready;
    logic [IW-1:0]   load_idx;
    logic [2:0]      load_code;
    logic            commit;
    logic            a;
    logic            b;
    logic            c;
    logic [NDIG-1:0] digen;
    logic            frame_tick;

    modport master (
        output enable, load_valid, load_idx, load_code, commit,
        input  load_ready, a, b, c, digen, frame_tick
    );

    modport slave (
        input  enable, load_valid, load_idx, load_code, commit,
        output load_ready, a, b, c, digen, frame_tick
    );
endinterface

// File: rtl/line_code_scanner.sv
// Double-buffered round-robin digit scanner with blanking gaps; all outputs registered (1-cycle latency).
// Loads are refused (load_ready=0) while a commit waits for the next frame boundary.
module line_code_scanner #(
    parameter int NDIG         = 4,
    parameter int DIG_CYCLES   = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input logic             clk,
    input logic             rst,
    line_code_scanner_if.slave bus
);
    localparam int IW   = $clog2(NDIG);
    localparam int MAXC = (DIG_CYCLES > BLANK_CYCLES) ? DIG_CYCLES : BLANK_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic {BLANK, SHOW} state_t;

    state_t                 state_q, state_n;
    logic [CW-1:0]          cnt_q, cnt_n;
    logic [IW-1:0]          idx_q, idx_n;
    logic [NDIG-1:0][2:0]   front_q, front_n;
    logic [NDIG-1:0][2:0]   shadow_q, shadow_n;
    logic                   pending_q, pending_n;
    logic                   ready_q;
    logic [2:0]             abc_q, abc_n;
    logic [NDIG-1:0]        digen_q, digen_n;
    logic                   tick_q;
    logic                   boundary;
    logic                   apply;
    logic                   wr_acc;
    logic                   cm_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= BLANK;
            cnt_q     <= '0;
            idx_q     <= '0;
            front_q   <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            ready_q   <= 1'b0;
            abc_q     <= '0;
            digen_q   <= '0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            idx_q     <= idx_n;
            front_q   <= front_n;
            shadow_q  <= shadow_n;
            pending_q <= pending_n;
            ready_q   <= ~pending_n;
            abc_q     <= abc_n;
            digen_q   <= digen_n;
            tick_q    <= boundary;
        end
    end

    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q + 1'b1;
        idx_n    = idx_q;
        boundary = 1'b0;
        if (!bus.enable) begin
            state_n = BLANK;
            cnt_n   = '0;
            idx_n   = '0;
        end else if (state_q == BLANK) begin
            if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
                state_n  = SHOW;
                cnt_n    = '0;
                boundary = (idx_q == '0);
            end
        end else if (cnt_q == CW'(DIG_CYCLES - 1)) begin
            state_n = BLANK;
            cnt_n   = '0;
            idx_n   = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    always_comb begin
        wr_acc    = bus.load_valid & ready_q;
        cm_acc    = bus.commit & ready_q;
        // A held commit lands at the frame boundary, or immediately while the scan is stopped.
        apply     = pending_q & (boundary | ~bus.enable);
        front_n   = apply ? shadow_q : front_q;
        pending_n = apply ? 1'b0 : (pending_q | cm_acc);
        shadow_n  = shadow_q;
        for (int i = 0; i < NDIG; i++) begin
            if (wr_acc && bus.load_idx == IW'(i)) begin
                shadow_n[i] = bus.load_code;
            end
        end
        digen_n = '0;
        abc_n   = '0;
        if (state_n == SHOW) begin
            digen_n = NDIG'(1) << idx_n;
            abc_n   = front_n[idx_n];
        end
    end

    assign bus.load_ready = ready_q;
    assign bus.a          = abc_q[2];
    assign bus.b          = abc_q[1];
    assign bus.c          = abc_q[0];
    assign bus.digen      = digen_q;
    assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_line_code_scanner.sv
// Randomised and directed bench: a frame-position reference model feeds a scoreboard queue drained by a monitor.
`timescale 1ns/1ps
module tb_line_code_scanner;
    localparam int NDIG  = 4;
    localparam int DC    = 4;
    localparam int BC    = 2;
    localparam int SLOT  = DC + BC;
    localparam int FRAME = NDIG * SLOT;

    typedef struct packed {
        logic [3:0] digen;
        logic [2:0] abc;
        logic       tick;
        logic       rdy;
    } obs_t;

    logic clk  = 1'b1;
    logic rst  = 1'b1;
    logic rst3 = 1'b1;
    always #5 clk = ~clk;

    line_code_scanner_if #(.NDIG(4)) bus ();
    line_code_scanner_if #(.NDIG(3)) bus3 ();

    line_code_scanner #(.NDIG(4), .DIG_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    line_code_scanner #(.NDIG(3), .DIG_CYCLES(2), .BLANK_CYCLES(1)) dut3 (
        .clk(clk), .rst(rst3), .bus(bus3)
    );

    int   nchk = 0;
    int   nerr = 0;
    int   ncyc = 0;
    bit   done3 = 0;
    obs_t exp_q[$];
    obs_t last;

    // reference model state: position of the current cycle inside the frame
    int         pos;
    logic [2:0] m_shadow[4];
    logic [2:0] m_front[4];
    bit         m_pending;
    bit         m_rdy;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        nchk++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic model_reset();
        pos       = 0;
        m_pending = 0;
        m_rdy     = 0;
        for (int i = 0; i < 4; i++) begin
            m_shadow[i] = 3'd0;
            m_front[i]  = 3'd0;
        end
    endtask

    task automatic step(input bit r, input bit en, input bit v, input int idx,
                        input logic [2:0] code, input bit cm);
        int   np;
        int   d;
        bit   bnd, app, acc, cacc, lit;
        obs_t o;
        @(negedge clk);
        rst            = r;
        bus.enable     = en;
        bus.load_valid = v;
        bus.load_idx   = 2'(idx);
        bus.load_code  = code;
        bus.commit     = cm;
        o = '0;
        if (r) begin
            model_reset();
        end else begin
            acc  = v && m_rdy;
            cacc = cm && m_rdy;
            np   = en ? (pos + 1) % FRAME : 0;
            bnd  = en && (np == BC);
            app  = m_pending && (bnd || !en);
            if (app) for (int i = 0; i < 4; i++) m_front[i] = m_shadow[i];
            if (acc && idx < NDIG) m_shadow[idx] = code;
            m_pending = app ? 1'b0 : (m_pending || cacc);
            m_rdy     = !m_pending;
            pos       = np;
            lit = (pos % SLOT) >= BC;
            d   = pos / SLOT;
            if (lit) begin
                o.digen = 4'(1 << d);
                o.abc   = m_front[d];
            end
            o.tick = bnd;
            o.rdy  = m_rdy;
        end
        last = o;
        exp_q.push_back(o);
    endtask

    task automatic idle(input int n, input bit en);
        for (int i = 0; i < n; i++) step(0, en, 0, 0, 3'd0, 0);
    endtask

    initial begin : monitor
        obs_t e;
        obs_t g;
        forever begin
            @(posedge clk);
            #1;
            ncyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = {bus.digen, bus.a, bus.b, bus.c, bus.frame_tick, bus.load_ready};
                check($sformatf("cycle%0d", ncyc), 32'(g), 32'(e));
            end
        end
    end

    initial begin : main
        logic [2:0] codes[4];
        int         n;
        bus.enable = 0; bus.load_valid = 0; bus.load_idx = 0; bus.load_code = 0; bus.commit = 0;
        model_reset();
        repeat (3) step(1, 1, 0, 0, 3'd0, 0);
        // scan with blank banks
        idle(50, 1);
        // write 5,3,6,7 then commit
        codes[0] = 3'd5; codes[1] = 3'd3; codes[2] = 3'd6; codes[3] = 3'd7;
        for (int i = 0; i < 4; i++) step(0, 1, 1, i, codes[i], 0);
        step(0, 1, 0, 0, 3'd0, 1);
        idle(55, 1);
        // same-cycle write+commit, then a commit while pending
        step(0, 1, 1, 2, 3'd4, 1);
        step(0, 1, 0, 0, 3'd0, 1);
        step(0, 1, 1, 1, 3'd1, 1);
        idle(55, 1);
        // uncommitted write never reaches the display
        step(0, 1, 1, 3, 3'd2, 0);
        idle(30, 1);
        // disable during digit 2, commit while disabled, re-enable
        n = 0;
        while (last.digen != 4'b0100 && n < 40) begin
            idle(1, 1);
            n++;
        end
        check("reach_digit2", 32'(last.digen), 32'h4);
        idle(2, 0);
        step(0, 0, 1, 1, 3'd2, 1);
        idle(3, 0);
        idle(30, 1);
        // reset mid-show with a commit pending
        step(0, 1, 1, 0, 3'd6, 1);
        n = 0;
        while (!(last.digen != 4'b0 && m_pending) && n < 40) begin
            idle(1, 1);
            n++;
        end
        check("pending_lit", 32'(m_pending), 32'h1);
        step(1, 1, 0, 0, 3'd0, 0);
        #1;
        check("rst_digen", 32'(bus.digen), 32'h0);
        check("rst_abc", 32'({bus.a, bus.b, bus.c}), 32'h0);
        check("rst_ready", 32'(bus.load_ready), 32'h0);
        check("rst_tick", 32'(bus.frame_tick), 32'h0);
        step(1, 1, 0, 0, 3'd0, 0);
        idle(50, 1);
        // randomised traffic
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 499) == 0,
                 $urandom_range(0, 99) < 95,
                 $urandom_range(0, 99) < 30,
                 $urandom_range(0, 3),
                 3'($urandom_range(0, 7)),
                 $urandom_range(0, 99) < 5);
        end
        idle(3, 1);
        n = 0;
        while (!done3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("n3_done", 32'(done3), 32'h1);
        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    // three-digit instance: an index equal to NDIG must be dropped
    initial begin : n3
        logic [2:0] want[3];
        int         seen;
        int         n;
        int         d;
        want[0] = 3'd1; want[1] = 3'd2; want[2] = 3'd3;
        bus3.enable = 0; bus3.load_valid = 0; bus3.load_idx = 0; bus3.load_code = 0; bus3.commit = 0;
        repeat (2) @(negedge clk);
        rst3 = 0;
        bus3.enable = 1;
        @(negedge clk);
        check("n3_ready", 32'(bus3.load_ready), 32'h1);
        for (int i = 0; i < 3; i++) begin
            bus3.load_valid = 1; bus3.load_idx = 2'(i); bus3.load_code = want[i];
            @(negedge clk);
        end
        bus3.load_idx = 2'd3; bus3.load_code = 3'd7; bus3.commit = 1;
        @(negedge clk);
        bus3.load_valid = 0; bus3.commit = 0;
        check("n3_pending", 32'(bus3.load_ready), 32'h0);
        n = 0;
        while (bus3.load_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("n3_commit_applied", 32'(bus3.load_ready), 32'h1);
        seen = 0;
        for (int k = 0; k < 9; k++) begin
            if (bus3.digen != 3'b000) begin
                check("n3_onehot", 32'($onehot(bus3.digen)), 32'h1);
                d = (bus3.digen == 3'b001) ? 0 : (bus3.digen == 3'b010) ? 1 : 2;
                check($sformatf("n3_code%0d", d), 32'({bus3.a, bus3.b, bus3.c}), 32'(want[d]));
                seen = seen | (1 << d);
            end
            @(negedge clk);
        end
        check("n3_all_digits", 32'(seen), 32'h7);
        done3 = 1;
    end
endmodule
